// File: rtl/wb_stage_if.sv
// Handshake and result bus between the MEM stage, the write-back stage and the register file.
// The write-back side uses the slave modport; the MEM stage and register file use master.
interface wb_stage_if #(
  parameter int XLEN   = 16,
  parameter int REG_AW = 3,
  parameter int LANE_W = $clog2(XLEN / 8)
) ();

  logic              valid_i;
  logic              ready_o;
  logic [REG_AW-1:0] rd_addr_i;
  logic              write_en_i;
  logic [1:0]        wb_sel_i;
  logic [XLEN-1:0]   alu_data_i;
  logic [XLEN-1:0]   pc_imm_i;
  logic [XLEN-1:0]   pc_link_i;
  logic [1:0]        mem_size_i;
  logic              mem_unsigned_i;
  logic [LANE_W-1:0] addr_lsb_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              flush_i;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic              pend_valid_o;
  logic [REG_AW-1:0] pend_rd_o;
  logic [31:0]       retire_cnt_o;

  modport slave (
    input  valid_i, rd_addr_i, write_en_i, wb_sel_i,
    input  alu_data_i, pc_imm_i, pc_link_i,
    input  mem_size_i, mem_unsigned_i, addr_lsb_i,
    input  mem_rvalid_i, mem_rdata_i, flush_i,
    output ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output pend_valid_o, pend_rd_o, retire_cnt_o
  );

  modport master (
    output valid_i, rd_addr_i, write_en_i, wb_sel_i,
    output alu_data_i, pc_imm_i, pc_link_i,
    output mem_size_i, mem_unsigned_i, addr_lsb_i,
    output mem_rvalid_i, mem_rdata_i, flush_i,
    input  ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  pend_valid_o, pend_rd_o, retire_cnt_o
  );

endinterface

// File: rtl/wb_stage.sv
// riscv-mini write-back stage: result select, variable-latency load wait, sub-word extract, RF write pulse.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int XLEN   = 16,
  parameter int REG_AW = 3,
  localparam int LANE_W = $clog2(XLEN / 8)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  wb_stage_if.slave   bus
);

  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC_IMM  = 2'd2;
  localparam logic [1:0] WB_PC_LINK = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t            state_r;
  logic [REG_AW-1:0] ld_rd_r;
  logic [1:0]        ld_size_r;
  logic              ld_unsigned_r;
  logic [LANE_W-1:0] ld_lane_r;

  logic              rf_we_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [XLEN-1:0]   rf_wdata_r;
  logic              pend_valid_r;
  logic [REG_AW-1:0] pend_rd_r;

  logic              ready_s;
  logic              accept_s;
  logic [XLEN-1:0]   sel_data_s;
  logic [31:0]       byte_shift_s;
  logic [31:0]       half_shift_s;
  logic [XLEN-1:0]   byte_word_s;
  logic [XLEN-1:0]   half_word_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [XLEN-1:0]   load_data_s;

  assign ready_s  = (state_r == IDLE);
  assign accept_s = bus.valid_i & ready_s;

  // Non-load result source mux.
  always_comb begin
    sel_data_s = bus.alu_data_i;
    case (bus.wb_sel_i)
      WB_ALU:     sel_data_s = bus.alu_data_i;
      WB_PC_IMM:  sel_data_s = bus.pc_imm_i;
      WB_PC_LINK: sel_data_s = bus.pc_link_i;
      default:    sel_data_s = bus.alu_data_i;
    endcase
  end

  // Sub-word extraction; shifting instead of part-selecting keeps every lane in range for any XLEN.
  always_comb begin
    byte_shift_s = 32'(ld_lane_r) << 3;
    half_shift_s = (32'(ld_lane_r) >> 1) << 4;
    byte_word_s  = bus.mem_rdata_i >> byte_shift_s;
    half_word_s  = bus.mem_rdata_i >> half_shift_s;
    byte_s       = byte_word_s[7:0];
    half_s       = half_word_s[15:0];
    load_data_s  = bus.mem_rdata_i;
    case (ld_size_r)
      SZ_BYTE: begin
        if (ld_unsigned_r) begin
          load_data_s = XLEN'(byte_s);
        end else begin
          load_data_s = XLEN'($signed(byte_s));
        end
      end
      SZ_HALF: begin
        if (ld_unsigned_r) begin
          load_data_s = XLEN'(half_s);
        end else begin
          load_data_s = XLEN'($signed(half_s));
        end
      end
      default: load_data_s = bus.mem_rdata_i;
    endcase
  end

  // Write-back FSM with registered register-file and hazard outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      ld_rd_r       <= '0;
      ld_size_r     <= 2'd0;
      ld_unsigned_r <= 1'b0;
      ld_lane_r     <= '0;
      rf_we_r       <= 1'b0;
      rf_waddr_r    <= '0;
      rf_wdata_r    <= '0;
      pend_valid_r  <= 1'b0;
      pend_rd_r     <= '0;
    end else begin
      rf_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && !bus.flush_i && bus.write_en_i) begin
            if (bus.wb_sel_i == WB_MEM) begin
              state_r       <= WAIT_MEM;
              ld_rd_r       <= bus.rd_addr_i;
              ld_size_r     <= bus.mem_size_i;
              ld_unsigned_r <= bus.mem_unsigned_i;
              ld_lane_r     <= bus.addr_lsb_i;
              pend_valid_r  <= (bus.rd_addr_i != '0);
              pend_rd_r     <= bus.rd_addr_i;
            end else begin
              state_r    <= IDLE;
              rf_waddr_r <= bus.rd_addr_i;
              rf_wdata_r <= sel_data_s;
              rf_we_r    <= (bus.rd_addr_i != '0);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_MEM: begin
          // A flush kills the load even if its data arrives in the same cycle.
          if (bus.flush_i) begin
            state_r      <= IDLE;
            pend_valid_r <= 1'b0;
            pend_rd_r    <= '0;
          end else if (bus.mem_rvalid_i) begin
            state_r      <= IDLE;
            rf_waddr_r   <= ld_rd_r;
            rf_wdata_r   <= load_data_s;
            rf_we_r      <= (ld_rd_r != '0);
            pend_valid_r <= 1'b0;
            pend_rd_r    <= '0;
          end else begin
            state_r <= WAIT_MEM;
          end
        end
        default: begin
          state_r      <= IDLE;
          pend_valid_r <= 1'b0;
          pend_rd_r    <= '0;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic        retire_s;
  logic [31:0] retire_cnt_r;

  // Stores, non-load writes and completed loads retire; flushed work does not.
  always_comb begin
    retire_s = 1'b0;
    if (state_r == IDLE) begin
      retire_s = accept_s & ~bus.flush_i & ~(bus.write_en_i & (bus.wb_sel_i == WB_MEM));
    end else begin
      retire_s = ~bus.flush_i & bus.mem_rvalid_i;
    end
  end

  // Free-running retire counter, wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_r <= 32'd0;
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign bus.retire_cnt_o = retire_cnt_r;
`else
  assign bus.retire_cnt_o = 32'd0;
`endif

  assign bus.ready_o      = ready_s;
  assign bus.rf_we_o      = rf_we_r;
  assign bus.rf_waddr_o   = rf_waddr_r;
  assign bus.rf_wdata_o   = rf_wdata_r;
  assign bus.pend_valid_o = pend_valid_r;
  assign bus.pend_rd_o    = pend_rd_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=16, REG_AW=3).
// Expected retire count follows WB_RETIRE_CNT_EN the same way the design does.
module tb_wb_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   exp_ret;

  wb_stage_if #(.XLEN(16), .REG_AW(3)) bus ();

  wb_stage #(.XLEN(16), .REG_AW(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.valid_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic we, input logic [1:0] sel);
    bus.valid_i    = 1'b1;
    bus.rd_addr_i  = rd;
    bus.write_en_i = we;
    bus.wb_sel_i   = sel;
  endtask

  // Full load: accept, two wait cycles, response, check write pulse.
  task automatic load(input string tag, input logic [2:0] rd, input logic [1:0] size,
                      input logic uns, input logic lsb, input logic [15:0] rdata,
                      input logic [15:0] exp);
    issue(rd, 1'b1, 2'd1);
    bus.mem_size_i     = size;
    bus.mem_unsigned_i = uns;
    bus.addr_lsb_i     = lsb;
    tick();
    quiet();
    bus.mem_unsigned_i = ~uns;
    bus.addr_lsb_i     = ~lsb;
    bus.mem_size_i     = 2'd2;
    chk({tag, "_ready_wait"}, 32'(bus.ready_o), 32'd0);
    chk({tag, "_pend_valid"}, 32'(bus.pend_valid_o), 32'(rd != 3'd0));
    chk({tag, "_pend_rd"}, 32'(bus.pend_rd_o), 32'(rd));
    tick();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rdata;
    chk({tag, "_ready_rvalid"}, 32'(bus.ready_o), 32'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 16'h0000;
    exp_ret++;
    chk({tag, "_we"}, 32'(bus.rf_we_o), 32'(rd != 3'd0));
    chk({tag, "_wdata"}, 32'(bus.rf_wdata_o), 32'(exp));
    chk({tag, "_waddr"}, 32'(bus.rf_waddr_o), 32'(rd));
    chk({tag, "_ready_after"}, 32'(bus.ready_o), 32'd1);
    chk({tag, "_pend_clear"}, 32'(bus.pend_valid_o), 32'd0);
    tick();
    chk({tag, "_we_drop"}, 32'(bus.rf_we_o), 32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_ret = 0;

    // Reset held with random inputs.
    rst_n              = 1'b0;
    bus.valid_i        = 1'b1;
    bus.rd_addr_i      = 3'($urandom);
    bus.write_en_i     = 1'b1;
    bus.wb_sel_i       = 2'($urandom);
    bus.alu_data_i     = 16'($urandom);
    bus.pc_imm_i       = 16'($urandom);
    bus.pc_link_i      = 16'($urandom);
    bus.mem_size_i     = 2'($urandom);
    bus.mem_unsigned_i = 1'($urandom);
    bus.addr_lsb_i     = 1'($urandom);
    bus.mem_rvalid_i   = 1'b1;
    bus.mem_rdata_i    = 16'($urandom);
    bus.flush_i        = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_we", 32'(bus.rf_we_o), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
    chk("rst_wdata", 32'(bus.rf_wdata_o), 32'd0);
    chk("rst_pend_valid", 32'(bus.pend_valid_o), 32'd0);
    chk("rst_pend_rd", 32'(bus.pend_rd_o), 32'd0);
    chk("rst_retire", bus.retire_cnt_o, 32'd0);
    quiet();
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 32'(bus.rf_we_o), 32'd0);

    // ALU write.
    issue(3'd3, 1'b1, 2'd0);
    bus.alu_data_i = 16'h1234;
    tick();
    quiet();
    exp_ret++;
    chk("alu_we", 32'(bus.rf_we_o), 32'd1);
    chk("alu_waddr", 32'(bus.rf_waddr_o), 32'd3);
    chk("alu_wdata", 32'(bus.rf_wdata_o), 32'h1234);
    tick();
    chk("alu_we_drop", 32'(bus.rf_we_o), 32'd0);

    // Loads: signed/unsigned byte in both lanes, half, full word.
    load("lb_hi", 3'd5, 2'd0, 1'b0, 1'b1, 16'h80FF, 16'hFF80);
    load("lbu_hi", 3'd5, 2'd0, 1'b1, 1'b1, 16'h80FF, 16'h0080);
    load("lb_lo", 3'd6, 2'd0, 1'b0, 1'b0, 16'h8074, 16'h0074);
    load("lb_lo_neg", 3'd6, 2'd0, 1'b0, 1'b0, 16'h12F0, 16'hFFF0);
    load("lh", 3'd4, 2'd1, 1'b0, 1'b1, 16'h80FF, 16'h80FF);
    load("lw", 3'd7, 2'd2, 1'b0, 1'b0, 16'h1357, 16'h1357);

    // Link to x0 never writes.
    issue(3'd0, 1'b1, 2'd3);
    bus.pc_link_i = 16'h0042;
    tick();
    quiet();
    exp_ret++;
    chk("x0_we", 32'(bus.rf_we_o), 32'd0);

    // Back-to-back link then PC+imm.
    issue(3'd1, 1'b1, 2'd3);
    tick();
    exp_ret++;
    chk("link_we", 32'(bus.rf_we_o), 32'd1);
    chk("link_wdata", 32'(bus.rf_wdata_o), 32'h0042);
    issue(3'd7, 1'b1, 2'd2);
    bus.pc_imm_i = 16'hBEEF;
    tick();
    quiet();
    exp_ret++;
    chk("imm_we", 32'(bus.rf_we_o), 32'd1);
    chk("imm_waddr", 32'(bus.rf_waddr_o), 32'd7);
    chk("imm_wdata", 32'(bus.rf_wdata_o), 32'hBEEF);
    tick();
    chk("imm_we_drop", 32'(bus.rf_we_o), 32'd0);

    // Flush racing load data.
    issue(3'd2, 1'b1, 2'd1);
    bus.mem_size_i = 2'd2;
    tick();
    quiet();
    chk("flush_pend_valid", 32'(bus.pend_valid_o), 32'd1);
    chk("flush_pend_rd", 32'(bus.pend_rd_o), 32'd2);
    bus.flush_i      = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 16'h5555;
    tick();
    quiet();
    chk("flush_we", 32'(bus.rf_we_o), 32'd0);
    chk("flush_ready", 32'(bus.ready_o), 32'd1);
    chk("flush_pend_clr", 32'(bus.pend_valid_o), 32'd0);
    chk("flush_pend_rd_clr", 32'(bus.pend_rd_o), 32'd0);

    // Store retires without writing or waiting.
    issue(3'd5, 1'b0, 2'd1);
    tick();
    quiet();
    exp_ret++;
    chk("store_we", 32'(bus.rf_we_o), 32'd0);
    chk("store_ready", 32'(bus.ready_o), 32'd1);

    // Flush on accept drops the instruction.
    issue(3'd4, 1'b1, 2'd0);
    bus.alu_data_i = 16'hAAAA;
    bus.flush_i    = 1'b1;
    tick();
    quiet();
    chk("drop_we", 32'(bus.rf_we_o), 32'd0);

    // Stray rvalid in IDLE is ignored.
    bus.mem_rvalid_i = 1'b1;
    tick();
    quiet();
    chk("idle_rvalid_we", 32'(bus.rf_we_o), 32'd0);
    chk("idle_rvalid_ready", 32'(bus.ready_o), 32'd1);

`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", bus.retire_cnt_o, 32'(exp_ret));
`else
    chk("retire_cnt", bus.retire_cnt_o, 32'd0);
`endif

    // Reset during a pending load abandons it.
    issue(3'd3, 1'b1, 2'd1);
    tick();
    quiet();
    chk("rstload_pend", 32'(bus.pend_valid_o), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rstload_ready_async", 32'(bus.ready_o), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 16'h7777;
    tick();
    quiet();
    chk("rstload_we", 32'(bus.rf_we_o), 32'd0);
    chk("rstload_pend_clr", 32'(bus.pend_valid_o), 32'd0);
    chk("rstload_retire", bus.retire_cnt_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised write-back stage for the riscv-mini core. It sits between the MEM stage and the register file. It accepts one instruction per handshake and selects the result from ALU, memory, PC+imm or PC-link. It waits for a variable-latency load response, extracts and extends sub-word loads, and drives a one-cycle register-file write pulse. It also exposes the pending load destination for load-use hazard detection.

## Interface
Parameters:
- XLEN, 16: data width; multiple of 8, ≥16.
- REG_AW, 3: register address width.
- LANE_W, $clog2(XLEN/8): byte-lane index width (derived, not overridden).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  MEM stage presents an instruction.
- ready_o  out  1  stage can accept (combinational from state).
- rd_addr_i  in  REG_AW  destination register.
- write_en_i  in  1  instruction writes rd.
- wb_sel_i  in  2  source: 0 WB_ALU, 1 WB_MEM, 2 WB_PC_IMM, 3 WB_PC_LINK.
- alu_data_i, pc_imm_i, pc_link_i  in  XLEN each  candidate results.
- mem_size_i  in  2  load size: 0 byte, 1 half, ≥2 full word.
- mem_unsigned_i  in  1  zero-extend (1) / sign-extend (0).
- addr_lsb_i  in  LANE_W  load address low bits.
- mem_rvalid_i  in  1  load data valid this cycle.
- mem_rdata_i  in  XLEN  load data word.
- flush_i  in  1  kill the accepted or pending instruction.
- rf_we_o  out  1  register-file write strobe, one-cycle pulse.
- rf_waddr_o  out  REG_AW  write address.
- rf_wdata_o  out  XLEN  write data.
- pend_valid_o  out  1  load outstanding to a nonzero rd.
- pend_rd_o  out  REG_AW  that rd.
- retire_cnt_o  out  32  retired-instruction count (see Configuration).

## Operation
- States: IDLE, WAIT_MEM. ready_o = (state == IDLE).
- Accept = valid_i & ready_o.
- IDLE, accept, flush_i=1: instruction dropped; no write; not retired; stay IDLE.
- IDLE, accept, write_en_i=0: retire; no write; stay IDLE. This applies to stores regardless of wb_sel_i.
- IDLE, accept, write_en_i=1, sel≠WB_MEM: register the selected source into rf_wdata_o and rd_addr_i into rf_waddr_o. rf_we_o=1 next cycle iff rd_addr_i≠0. Retire; stay IDLE.
- IDLE, accept, write_en_i=1, sel=WB_MEM: latch rd, size, unsigned and lane; go to WAIT_MEM.
- WAIT_MEM, flush_i=1: go to IDLE; no write; not retired. flush_i wins over a simultaneous mem_rvalid_i.
- WAIT_MEM, mem_rvalid_i=1: extract data, register it, rf_we_o=1 next cycle iff latched rd≠0. Retire; go to IDLE.
- mem_rvalid_i in IDLE is ignored.
- Extraction:
  - Byte: mem_rdata_i[8*lane +: 8].
  - Half: mem_rdata_i[16*lane[LANE_W-1:1] +: 16]. For XLEN=16 this is the full word.
  - Word: mem_rdata_i unmodified.
  - Byte and half results are sign- or zero-extended to XLEN per the latched unsigned bit.
- rd=0 never asserts rf_we_o. rf_waddr_o and rf_wdata_o may still update.
- pend_valid_o = (state==WAIT_MEM) & (latched rd≠0). pend_rd_o = latched rd, else 0.

## Timing
- Reset (rst_ni low, async):
  - state=IDLE, so ready_o=1.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - pend_valid_o=0, pend_rd_o=0, retire_cnt_o=0.
- Reset asserted mid-WAIT_MEM abandons the load; no write occurs after release.
- Non-load latency: 1 cycle from accept to rf_we_o.
- Load latency: 1 cycle from mem_rvalid_i to rf_we_o. ready_o is low from the cycle after accept through the mem_rvalid_i cycle.
- rf_we_o is high for exactly one cycle per write.
- Back-to-back non-load accepts give consecutive rf_we_o pulses.
- Throughput: 1 instruction/cycle for non-loads; one outstanding load maximum.

## Configuration
- WB_RETIRE_CNT_EN defined: retire_cnt_o is a 32-bit counter.
  - Increments by 1 per retire as defined in Operation.
  - Wraps at 2^32−1 → 0.
  - Does not count flushed or dropped instructions.
- WB_RETIRE_CNT_EN undefined: retire_cnt_o tied to 0; no counter flops.

## Test plan
- Reset: hold rst_ni=0 with random inputs → all outputs 0, ready_o=1. Release: first accept behaves normally.
- ALU write: accept rd=3, sel=0, alu=0x1234 → next cycle rf_we_o=1, waddr=3, wdata=0x1234; the following cycle rf_we_o=0.
- Signed byte load: accept rd=5, sel=1, size=0, unsigned=0, lsb=1. mem_rvalid_i 2 cycles later with rdata=0x80FF.
  - While waiting: ready_o=0, pend_valid_o=1, pend_rd_o=5.
  - Cycle after rvalid: rf_we_o=1, wdata=0xFF80.
  - Repeat with unsigned=1 → 0x0080.
- x0 and link: accept rd=0, sel=3, pc_link=0x0042 → rf_we_o stays 0. Same with rd=1 → wdata=0x0042.
- Flush race: load to rd=2, then flush_i=1 and mem_rvalid_i=1 in the same cycle → no rf_we_o, ready_o=1 next cycle, pend_valid_o=0.
- Counter (macro defined): ALU, store, load (completed), flushed load → retire_cnt_o=3. With the macro undefined → retire_cnt_o=0.
